ili_init_seq: RTL and testbench

ILI_INIT_SEQ -- requirements
Module: ili_init_seq

---
 rtl/ili_init_seq_pkg.sv | 43 ++++
 rtl/ili_init_seq_ms_tick.sv | 34 +++
 rtl/ili_init_seq.sv | 195 +++++++++++++++++++
 tb/tb_ili_init_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ili_init_seq_pkg.sv
// Shared types for the ILI9341 init sequencer: entry kinds, FSM states,
// entry width and the default ILI9341 power-up table.
package ili_pkg;

    typedef enum logic [1:0] {
        K_CMD   = 2'd0,
        K_DATA  = 2'd1,
        K_DELAY = 2'd2,
        K_END   = 2'd3
    } kind_e;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RST_LO   = 4'd1,
        S_RST_WAIT = 4'd2,
        S_FETCH    = 4'd3,
        S_SEND     = 4'd4,
        S_DELAY    = 4'd5,
        S_FINISH   = 4'd6
    } state_e;

    localparam int DEF_DW  = 8;
    localparam int ENTRY_W = 2 + DEF_DW;

    // Minimal bring-up: soft reset, sleep out, 16-bit pixels, BGR order, display on.
    function automatic logic [ENTRY_W-1:0] ili9341_entry(input int idx);
        logic [ENTRY_W-1:0] e;
        case (idx)
            0:       e = {K_CMD,   8'h01};
            1:       e = {K_DELAY, 8'd5};
            2:       e = {K_CMD,   8'h11};
            3:       e = {K_DELAY, 8'd120};
            4:       e = {K_CMD,   8'h3A};
            5:       e = {K_DATA,  8'h55};
            6:       e = {K_CMD,   8'h36};
            7:       e = {K_DATA,  8'h48};
            8:       e = {K_CMD,   8'h29};
            default: e = {K_END,   8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ili_init_seq_ms_tick.sv
// Millisecond tick generator; clr restarts the count so that the cycle in
// which clr is high is cycle 0 of a fresh millisecond.
module ili_ms_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PERIOD = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_comb begin
        tick = clr ? (PERIOD == 1) : (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= (PERIOD == 1) ? '0 : CW'(1);
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ili_init_seq.sv
// ili_init_seq: pulses the panel reset, then streams a ROM of command/data/
// delay entries to an SPI byte transmitter. Define ILI_INIT_SEQ_DBG_EN to add
// the dbg_index/dbg_state outputs.
module ili_init_seq
    import ili_pkg::*;
#(
    parameter int DW          = 8,
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEPTH       = 64,
    parameter int RST_LOW_MS  = 1,
    parameter int RST_WAIT_MS = 120,
    parameter bit USE_DEFAULT_ROM = 1'b1,
    parameter logic [DEPTH*(DW+2)-1:0] ROM_IMAGE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          tx_ready,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    output logic          tx_dc,
    output logic          cs_n,
    output logic          rst_n,
    output logic          busy,
    output logic          done
`ifdef ILI_INIT_SEQ_DBG_EN
    ,
    output logic [$clog2(DEPTH)-1:0] dbg_index,
    output logic [3:0]               dbg_state
`endif
);

    // tx_valid/tx_ready: a byte transfers on a cycle where both are high;
    // tx_valid, tx_data and tx_dc hold unchanged until that cycle.

    localparam int EW = DW + 2;
    localparam int IW = $clog2(DEPTH + 1);
    localparam int MW = (DW > 16) ? DW : 16;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH);

    function automatic logic [EW-1:0] rom_entry(input int i);
        logic [ENTRY_W-1:0] d;
        d = ili9341_entry(i);
        if (USE_DEFAULT_ROM) begin
            return {d[ENTRY_W-1 -: 2], DW'(d[DEF_DW-1:0])};
        end
        return ROM_IMAGE[i*EW +: EW];
    endfunction

    state_e        state;
    logic [IW-1:0] index;
    logic [IW-1:0] rd_addr;
    logic [MW-1:0] ms_cnt;
    logic [MW-1:0] dly_ms;
    logic [EW-1:0] rom_q;
    logic          tick_clr;
    logic          tick;
    kind_e         rom_kind;
    logic [DW-1:0] rom_payload;

    ili_ms_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    // Read ahead on acceptance so FETCH sees the next entry in its first cycle.
    always_comb begin
        rd_addr = (state == S_SEND && tx_ready) ? index + IW'(1) : index;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_q <= '0;
        end else begin
            rom_q <= (rd_addr < LAST_IDX) ? rom_entry(int'(rd_addr)) : {K_END, {DW{1'b0}}};
        end
    end

    assign rom_kind    = kind_e'(rom_q[EW-1 -: 2]);
    assign rom_payload = rom_q[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            index    <= '0;
            ms_cnt   <= '0;
            dly_ms   <= '0;
            tick_clr <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_dc    <= 1'b0;
            cs_n     <= 1'b1;
            rst_n    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tick_clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RST_LO;
                        tick_clr <= 1'b1;
                        ms_cnt   <= '0;
                        index    <= '0;
                        rst_n    <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_RST_LO: begin
                    if (tick) begin
                        if (ms_cnt == MW'(RST_LOW_MS - 1)) begin
                            state    <= S_RST_WAIT;
                            tick_clr <= 1'b1;
                            ms_cnt   <= '0;
                            rst_n    <= 1'b1;
                        end else begin
                            ms_cnt <= ms_cnt + MW'(1);
                        end
                    end
                end
                S_RST_WAIT: begin
                    if (tick) begin
                        if (ms_cnt == MW'(RST_WAIT_MS - 1)) begin
                            state    <= S_FETCH;
                            tick_clr <= 1'b1;
                            ms_cnt   <= '0;
                            cs_n     <= 1'b0;
                        end else begin
                            ms_cnt <= ms_cnt + MW'(1);
                        end
                    end
                end
                S_FETCH: begin
                    tick_clr <= 1'b1;
                    // Running off the end of the ROM behaves like an END entry.
                    if (index == LAST_IDX || rom_kind == K_END) begin
                        state <= S_FINISH;
                        cs_n  <= 1'b1;
                    end else if (rom_kind == K_DELAY) begin
                        state  <= S_DELAY;
                        dly_ms <= MW'(rom_payload);
                        ms_cnt <= '0;
                        index  <= index + IW'(1);
                    end else begin
                        state    <= S_SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= rom_payload;
                        tx_dc    <= rom_q[DW];
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        state    <= S_FETCH;
                        tick_clr <= 1'b1;
                        tx_valid <= 1'b0;
                        index    <= index + IW'(1);
                    end
                end
                S_DELAY: begin
                    if (dly_ms == '0) begin
                        state    <= S_FETCH;
                        tick_clr <= 1'b1;
                    end else if (tick) begin
                        if (ms_cnt == dly_ms - MW'(1)) begin
                            state    <= S_FETCH;
                            tick_clr <= 1'b1;
                        end else begin
                            ms_cnt <= ms_cnt + MW'(1);
                        end
                    end
                end
                S_FINISH: begin
                    state    <= S_IDLE;
                    tick_clr <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ILI_INIT_SEQ_DBG_EN
    assign dbg_index = index[$clog2(DEPTH)-1:0];
    assign dbg_state = state;
`endif

endmodule

// File: tb/tb_ili_init_seq.sv
// Directed bench for ili_init_seq at CLK_HZ=10_000 (1 ms = 10 cycles), with four
// instances: default table, stalled CMD/DATA, DELAY entry, and a ROM with no END.
module tb_ili_init_seq;

    localparam int CLK_HZ = 10_000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start_d, ready_d, valid_d, dc_d, csn_d, rstn_d, busy_d, done_d;
    logic start_a, ready_a, valid_a, dc_a, csn_a, rstn_a, busy_a, done_a;
    logic start_b, ready_b, valid_b, dc_b, csn_b, rstn_b, busy_b, done_b;
    logic start_c, ready_c, valid_c, dc_c, csn_c, rstn_c, busy_c, done_c;
    logic [7:0] data_d, data_a, data_b, data_c;

    ili_init_seq #(.DW(8), .CLK_HZ(CLK_HZ), .DEPTH(64), .RST_LOW_MS(1), .RST_WAIT_MS(2),
                   .USE_DEFAULT_ROM(1'b1)) u_def (
        .clk(clk), .rst(rst), .start(start_d), .tx_ready(ready_d), .tx_valid(valid_d),
        .tx_data(data_d), .tx_dc(dc_d), .cs_n(csn_d), .rst_n(rstn_d), .busy(busy_d), .done(done_d));

    ili_init_seq #(.DW(8), .CLK_HZ(CLK_HZ), .DEPTH(4), .RST_LOW_MS(1), .RST_WAIT_MS(2),
                   .USE_DEFAULT_ROM(1'b0),
                   .ROM_IMAGE({10'h300, 10'h300, 10'h148, 10'h036})) u_a (
        .clk(clk), .rst(rst), .start(start_a), .tx_ready(ready_a), .tx_valid(valid_a),
        .tx_data(data_a), .tx_dc(dc_a), .cs_n(csn_a), .rst_n(rstn_a), .busy(busy_a), .done(done_a));

    ili_init_seq #(.DW(8), .CLK_HZ(CLK_HZ), .DEPTH(4), .RST_LOW_MS(1), .RST_WAIT_MS(2),
                   .USE_DEFAULT_ROM(1'b0),
                   .ROM_IMAGE({10'h300, 10'h029, 10'h203, 10'h011})) u_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_ready(ready_b), .tx_valid(valid_b),
        .tx_data(data_b), .tx_dc(dc_b), .cs_n(csn_b), .rst_n(rstn_b), .busy(busy_b), .done(done_b));

    ili_init_seq #(.DW(8), .CLK_HZ(CLK_HZ), .DEPTH(4), .RST_LOW_MS(1), .RST_WAIT_MS(2),
                   .USE_DEFAULT_ROM(1'b0),
                   .ROM_IMAGE({10'h0A3, 10'h1A2, 10'h1A1, 10'h0A0})) u_c (
        .clk(clk), .rst(rst), .start(start_c), .tx_ready(ready_c), .tx_valid(valid_c),
        .tx_data(data_c), .tx_dc(dc_c), .cs_n(csn_c), .rst_n(rstn_c), .busy(busy_c), .done(done_c));

    // Accepted bytes per instance as {dc, data}, plus cycle stamps for the delay gap.
    logic [8:0] got_d[$], got_a[$], got_b[$], got_c[$];
    int cyc = 0;
    int acc11 = -1;
    int off29 = -1;

    always @(posedge clk) begin
        if (valid_d && ready_d) got_d.push_back({dc_d, data_d});
        if (valid_a && ready_a) got_a.push_back({dc_a, data_a});
        if (valid_b && ready_b) got_b.push_back({dc_b, data_b});
        if (valid_c && ready_c) got_c.push_back({dc_c, data_c});
        if (valid_b && ready_b && data_b == 8'h11) acc11 <= cyc;
        if (valid_b && data_b == 8'h29 && off29 < 0) off29 <= cyc;
        cyc <= cyc + 1;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];
    logic [8:0] cap_q[$];
    localparam logic [13:0] RST_VEC = 14'h00C;  // {valid,dc,data,cs_n,rst_n,busy,done}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input int base);
        check({tag, "_count"}, 32'(cap_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (base + i < cap_q.size()) ? 32'(cap_q[base + i]) : 32'hDEAD, 32'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    initial begin
        int n;
        int gap;
        rst = 1'b1;
        {start_d, start_a, start_b, start_c} = '0;
        {ready_d, ready_a, ready_b, ready_c} = '0;
        repeat (3) @(negedge clk);
        check("reset_def", {valid_d, dc_d, data_d, csn_d, rstn_d, busy_d, done_d}, RST_VEC);
        check("reset_c", {valid_c, dc_c, data_c, csn_c, rstn_c, busy_c, done_c}, RST_VEC);
        rst = 1'b0;
        @(negedge clk);

        // Default table: panel reset timing then the ILI9341 byte stream.
        ready_d = 1'b1;
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        check("def_busy", busy_d, 1);
        n = 0;
        while (rstn_d === 1'b0 && n < 100) begin n++; @(negedge clk); end
        check("def_rst_lo_cycles", n, 10);
        n = 0;
        while (csn_d === 1'b1 && n < 100) begin n++; @(negedge clk); end
        check("def_rst_wait_cycles", n, 20);
        check("def_rstn_released", rstn_d, 1);
        n = 0;
        while (!done_d && n < 3000) begin n++; @(negedge clk); end
        check("def_done_in_time", n < 3000, 1);
        check("def_end_state", {done_d, busy_d, csn_d}, 3'b101);
        exp_q = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
        cap_q = got_d;
        check_bytes("def", 0);

        // Stalled transmitter: first byte must hold and be taken once.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!valid_a && n < 200) begin n++; @(negedge clk); end
        check("a_offer_in_time", n < 200, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("a_hold%0d", i), {valid_a, dc_a, data_a}, {1'b1, 1'b0, 8'h36});
            @(negedge clk);
        end
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        @(negedge clk);
        check("a_second_offer", {valid_a, dc_a, data_a}, {1'b1, 1'b1, 8'h48});
        check("a_accepted_once", got_a.size(), 1);

        // Reset while the second byte is being offered.
        rst = 1'b1;
        @(negedge clk);
        check("a_reset_mid_send", {valid_a, dc_a, data_a, csn_a, rstn_a, busy_a, done_a}, RST_VEC);
        rst = 1'b0;
        ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 300) begin n++; @(negedge clk); end
        check("a_rerun_done", done_a, 1);
        exp_q = '{9'h036, 9'h148};
        cap_q = got_a;
        check_bytes("a_rerun", 1);

        // Start with done set clears done and runs again.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_restart_flags", {done_a, busy_a}, 2'b01);
        n = 0;
        while (!done_a && n < 300) begin n++; @(negedge clk); end
        check("a_restart_bytes", got_a.size(), 5);

        // DELAY 3 between two commands.
        ready_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 500) begin n++; @(negedge clk); end
        check("b_done", done_b, 1);
        exp_q = '{9'h011, 9'h029};
        cap_q = got_b;
        check_bytes("b", 0);
        gap = off29 - acc11 - 1;
        check("b_gap_30_pm2", (acc11 >= 0 && gap >= 28 && gap <= 32), 1);

        // No END entry, with a second start while busy.
        ready_c = 1'b1;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        repeat (5) @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        n = 0;
        while (!done_c && n < 500) begin n++; @(negedge clk); end
        check("c_end_state", {done_c, busy_c, csn_c}, 3'b101);
        exp_q = '{9'h0A0, 9'h1A1, 9'h1A2, 9'h0A3};
        cap_q = got_c;
        check_bytes("c", 0);
        repeat (40) @(negedge clk);
        check("c_single_run", {got_c.size() == 4, busy_c}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
